// File: rtl/noc_pkg.sv
// Shared definitions for the mesh router's per-output scheduling logic.
// Contents:
//   NUM_PORTS / FLIT_W : port count and flit width of the router.
//   DIR_*              : one-hot direction codes (L=4, R=3, U=2, D=1, PE=0).
//   arb_state_e        : output buffer state (EMPTY / FULL).
//   idx2onehot/onehot2idx : conversions between port index and one-hot code.
package noc_pkg;

    localparam int NUM_PORTS = 5;
    localparam int FLIT_W    = 64;
    localparam int IDX_W     = 3;

    localparam logic [NUM_PORTS-1:0] DIR_L  = 5'b10000;
    localparam logic [NUM_PORTS-1:0] DIR_R  = 5'b01000;
    localparam logic [NUM_PORTS-1:0] DIR_U  = 5'b00100;
    localparam logic [NUM_PORTS-1:0] DIR_D  = 5'b00010;
    localparam logic [NUM_PORTS-1:0] DIR_PE = 5'b00001;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_e;

    function automatic logic [NUM_PORTS-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_PORTS-1:0] oh;
        for (int i = 0; i < NUM_PORTS; i++) begin
            oh[i] = (idx == IDX_W'(i));
        end
        return oh;
    endfunction

    function automatic logic [IDX_W-1:0] onehot2idx(input logic [NUM_PORTS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/output_arbiter_if.sv
// Bundle of everything that crosses the boundary of one output scheduler.
//   req_i     : per-input request bits for this output (L=4 .. PE=0)
//   data*_i   : head flit of each input channel
//   clr_o     : one-hot buffer-clear pulse to the winning input channel
//   so_o/ro_i : send/ready pair toward the downstream router or PE
//   data_o    : held output flit; busy_o mirrors so_o
//   dbg_*     : buffer state, round-robin pointer and U-turn request flag
//
// Handshake: so_o (valid) stays high while a flit is held and data_o is
// stable until the flit is taken. A flit moves downstream on every rising
// edge where so_o & ro_i; ro_i is ignored when so_o is low. On the request
// side, clr_o[k] high in a cycle means input k's flit is taken on the
// closing edge of that cycle.
interface output_arbiter_if
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REQ    = 5
) ();

    logic [NUM_REQ-1:0]         req_i;
    logic [DATA_WIDTH-1:0]      dataL_i;
    logic [DATA_WIDTH-1:0]      dataR_i;
    logic [DATA_WIDTH-1:0]      dataU_i;
    logic [DATA_WIDTH-1:0]      dataD_i;
    logic [DATA_WIDTH-1:0]      dataPE_i;
    logic                       ro_i;
    logic                       so_o;
    logic [DATA_WIDTH-1:0]      data_o;
    logic [NUM_REQ-1:0]         clr_o;
    logic                       busy_o;
    arb_state_e                 dbg_state;
    logic [$clog2(NUM_REQ)-1:0] dbg_ptr;
    logic                       dbg_uturn;

    modport slave (
        input  req_i, dataL_i, dataR_i, dataU_i, dataD_i, dataPE_i, ro_i,
        output so_o, data_o, clr_o, busy_o, dbg_state, dbg_ptr, dbg_uturn
    );

    modport master (
        output req_i, dataL_i, dataR_i, dataU_i, dataD_i, dataPE_i, ro_i,
        input  so_o, data_o, clr_o, busy_o, dbg_state, dbg_ptr, dbg_uturn
    );

endinterface

// File: rtl/output_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : request vector
//   ptr : highest-priority index; search runs ptr, ptr+1, ... wrapping N-1 -> 0
//   gnt : one-hot grant (zero when nothing requests)
//   idx : index of the granted requester
//   any : at least one request present
module rr_arbiter #(
    parameter int N  = 5,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_arbiter.sv
// Per-output-port scheduler of the mesh router. Picks one of up to five
// requesting inputs round-robin, copies its flit into a one-entry output
// buffer, pulses clr_o to the winner and offers the flit downstream with
// the so_o/ro_i handshake.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : output_arbiter_if slave modport (requests, flits, handshake, debug)
module output_arbiter
    import noc_pkg::*;
#(
    parameter int                 DATA_WIDTH = FLIT_W,
    parameter int                 NUM_REQ    = NUM_PORTS,
    parameter logic [NUM_REQ-1:0] DIRECTION  = 5'b00001
) (
    input  logic             clk,
    input  logic             rst,
    output_arbiter_if.slave  bus
);

    localparam int IW = $clog2(NUM_REQ);

    arb_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [IW-1:0]         ptr_q, ptr_d;

    logic [NUM_REQ-1:0]    win_gnt;
    logic [IW-1:0]         win_idx;
    logic                  win_any;
    logic                  accept;
    logic                  grant;
    logic [DATA_WIDTH-1:0] win_data;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req (bus.req_i),
        .ptr (ptr_q),
        .gnt (win_gnt),
        .idx (win_idx),
        .any (win_any)
    );

    // The buffer can take a new flit when empty, or when the held flit is
    // leaving this very edge (back-to-back, one flit per cycle).
    assign accept = (state_q == ST_EMPTY) || bus.ro_i;
    assign grant  = accept && win_any;

    always_comb begin
        win_data = '0;
        case (win_idx)
            IW'(4):  win_data = bus.dataL_i;
            IW'(3):  win_data = bus.dataR_i;
            IW'(2):  win_data = bus.dataU_i;
            IW'(1):  win_data = bus.dataD_i;
            IW'(0):  win_data = bus.dataPE_i;
            default: win_data = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        if (grant) begin
            state_d = ST_FULL;
            data_d  = win_data;
            ptr_d   = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
        end else if ((state_q == ST_FULL) && bus.ro_i) begin
            // Flit taken with nothing to replace it; data_o keeps its value.
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
        end
    end

    // clr_o is gated by rst so input channels keep their flits during reset.
    assign bus.clr_o     = (rst && grant) ? win_gnt : '0;
    assign bus.so_o      = (state_q == ST_FULL);
    assign bus.busy_o    = (state_q == ST_FULL);
    assign bus.data_o    = data_q;
    assign bus.dbg_state = state_q;
    assign bus.dbg_ptr   = ptr_q;
    // A request from our own direction is a U-turn; routing should never
    // produce one, but it is arbitrated normally and flagged here.
    assign bus.dbg_uturn = |(bus.req_i & DIRECTION);

endmodule

// File: tb/tb_output_arbiter.sv
// Directed-vector bench for output_arbiter.
module tb_output_arbiter;
    import noc_pkg::*;

    localparam logic [63:0] D_L  = 64'h4C;
    localparam logic [63:0] D_R  = 64'hA5;
    localparam logic [63:0] D_U  = 64'h2A;
    localparam logic [63:0] D_D  = 64'h1D;
    localparam logic [63:0] D_PE = 64'h0E;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    output_arbiter_if #(.DATA_WIDTH(64), .NUM_REQ(5)) bus ();

    output_arbiter #(
        .DATA_WIDTH (64),
        .NUM_REQ    (5),
        .DIRECTION  (5'b00001)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- directed vectors ----------------
    logic [4:0]  fair_clr [6];
    logic [63:0] fair_dat [6];

    initial begin
        n_vec = 0;
        n_err = 0;
        fair_clr[0] = 5'b00001; fair_dat[0] = D_PE;
        fair_clr[1] = 5'b00010; fair_dat[1] = D_D;
        fair_clr[2] = 5'b00100; fair_dat[2] = D_U;
        fair_clr[3] = 5'b01000; fair_dat[3] = D_R;
        fair_clr[4] = 5'b10000; fair_dat[4] = D_L;
        fair_clr[5] = 5'b00001; fair_dat[5] = D_PE;

        rst          = 1'b0;
        bus.req_i    = 5'b11111;
        bus.ro_i     = 1'b0;
        bus.dataL_i  = D_L;
        bus.dataR_i  = D_R;
        bus.dataU_i  = D_U;
        bus.dataD_i  = D_D;
        bus.dataPE_i = D_PE;

        // 1 reset with all requests asserted
        repeat (3) step();
        check("rst_so",    64'(bus.so_o),    64'd0);
        check("rst_busy",  64'(bus.busy_o),  64'd0);
        check("rst_clr",   64'(bus.clr_o),   64'd0);
        check("rst_data",  bus.data_o,       64'd0);
        check("rst_ptr",   64'(bus.dbg_ptr), 64'd0);
        check("rst_uturn", 64'(bus.dbg_uturn), 64'd1);
        rst = 1'b1;
        #1;
        check("first_grant_clr", 64'(bus.clr_o), 64'b00001);
        step();
        check("first_grant_so",   64'(bus.so_o), 64'd1);
        check("first_grant_data", bus.data_o,    D_PE);
        bus.req_i = 5'b00000;
        bus.ro_i  = 1'b1;
        step();
        check("first_drain_so", 64'(bus.so_o), 64'd0);
        check("first_drain_data_hold", bus.data_o, D_PE);

        // 2 single request from R (ptr=1)
        bus.req_i = 5'b01000;
        #1;
        check("single_clr", 64'(bus.clr_o), 64'b01000);
        step();
        bus.req_i = 5'b00000;
        check("single_so",   64'(bus.so_o), 64'd1);
        check("single_data", bus.data_o,    D_R);
        #1;
        check("single_clr_off", 64'(bus.clr_o), 64'd0);
        step();
        check("single_so_off", 64'(bus.so_o), 64'd0);

        // bring ptr from 4 back to 0 with an L grant
        bus.req_i = 5'b10000;
        #1;
        check("l_only_clr", 64'(bus.clr_o), 64'b10000);
        step();
        bus.req_i = 5'b00000;
        step();
        check("ptr_zero", 64'(bus.dbg_ptr), 64'd0);

        // 3 fairness, all requesting with ro_i=1
        bus.req_i = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("fair_clr%0d", k), 64'(bus.clr_o), 64'(fair_clr[k]));
            if (k > 0) begin
                check($sformatf("fair_so%0d", k),   64'(bus.so_o), 64'd1);
                check($sformatf("fair_data%0d", k), bus.data_o,    fair_dat[k-1]);
            end
            step();
        end
        check("fair_so_end",   64'(bus.so_o), 64'd1);
        check("fair_data_end", bus.data_o,    D_PE);
        bus.req_i = 5'b00000;
        step();
        check("fair_drain_so", 64'(bus.so_o), 64'd0);

        // 4 backpressure: ptr=1, U requests while downstream stalls
        bus.req_i = 5'b00100;
        bus.ro_i  = 1'b0;
        #1;
        check("bp_first_clr", 64'(bus.clr_o), 64'b00100);
        step();
        bus.dataU_i = 64'h2B;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("bp_clr%0d", k),  64'(bus.clr_o), 64'd0);
            check($sformatf("bp_data%0d", k), bus.data_o,     D_U);
            check($sformatf("bp_so%0d", k),   64'(bus.so_o),  64'd1);
            step();
        end
        bus.ro_i = 1'b1;
        #1;
        check("bp_release_clr", 64'(bus.clr_o), 64'b00100);
        step();
        check("bp_new_data", bus.data_o,    64'h2B);
        check("bp_new_so",   64'(bus.so_o), 64'd1);
        bus.req_i = 5'b00000;
        step();
        check("bp_drain_so", 64'(bus.so_o), 64'd0);

        // 5 wrap: ptr=3, R grant sets ptr=4, then L wins, then PE
        bus.req_i = 5'b01000;
        #1;
        check("wrap_r_clr", 64'(bus.clr_o), 64'b01000);
        step();
        check("wrap_ptr4", 64'(bus.dbg_ptr), 64'd4);
        bus.req_i = 5'b10001;
        #1;
        check("wrap_l_clr", 64'(bus.clr_o), 64'b10000);
        step();
        check("wrap_l_data", bus.data_o,       D_L);
        check("wrap_ptr0",   64'(bus.dbg_ptr), 64'd0);
        #1;
        check("wrap_pe_clr", 64'(bus.clr_o), 64'b00001);
        step();
        check("wrap_pe_data", bus.data_o,       D_PE);
        check("wrap_ptr1",    64'(bus.dbg_ptr), 64'd1);
        bus.req_i = 5'b00000;
        step();

        // 6 mid-operation reset with a held flit
        bus.ro_i    = 1'b0;
        bus.dataD_i = 64'hDEAD;
        bus.req_i   = 5'b00010;
        #1;
        check("mid_clr", 64'(bus.clr_o), 64'b00010);
        step();
        bus.req_i = 5'b00000;
        check("mid_so",   64'(bus.so_o), 64'd1);
        check("mid_data", bus.data_o,    64'hDEAD);
        step();
        check("mid_hold_so", 64'(bus.so_o), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_so",   64'(bus.so_o),   64'd0);
        check("mid_rst_busy", 64'(bus.busy_o), 64'd0);
        check("mid_rst_data", bus.data_o,      64'd0);
        step();
        rst      = 1'b1;
        bus.ro_i = 1'b1;
        step();
        check("post_rst_so",  64'(bus.so_o),    64'd0);
        check("post_rst_ptr", 64'(bus.dbg_ptr), 64'd0);
        check("post_rst_clr", 64'(bus.clr_o),   64'd0);

        // ---------------- final report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
